// File: rtl/mdu_div_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface mdu_div_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, word, a, b, flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, word, a, b, flush, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_div_ctrl.sv
// RV64M divide sequencer: radix-2 restoring DIV/DIVU/REM/REMU (+W) with
// early exit for divide-by-zero and signed overflow.
module mdu_div_ctrl #(
  parameter int XLEN = 64
) (
  input logic       clk,
  input logic       reset,
  mdu_div_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic            is_rem;
  logic            word_q;
  logic            q_neg;
  logic            r_neg;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] dvs;
  logic [CW-1:0]   cnt;

  // W results are always the sign-extended low word, unsigned ops included.
  function automatic logic [XLEN-1:0] fix_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  logic                   sgn;
  logic                   fire;
  logic signed [XLEN-1:0] ext_a;
  logic signed [XLEN-1:0] ext_b;
  logic signed [XLEN-1:0] min_val;
  logic                   a_neg;
  logic                   b_neg;
  logic [XLEN-1:0]        abs_a;
  logic [XLEN-1:0]        abs_b;
  logic                   div_zero;
  logic                   ovf;
  logic [XLEN-1:0]        sp_res;

  assign sgn  = ~bus.op[0];
  assign fire = bus.in_valid && (state == IDLE) && !bus.flush;

  always_comb begin
    ext_a   = bus.a;
    ext_b   = bus.b;
    min_val = {1'b1, {(XLEN-1){1'b0}}};
    if (bus.word) begin
      ext_a   = sgn ? {{(XLEN-32){bus.a[31]}}, bus.a[31:0]} : {{(XLEN-32){1'b0}}, bus.a[31:0]};
      ext_b   = sgn ? {{(XLEN-32){bus.b[31]}}, bus.b[31:0]} : {{(XLEN-32){1'b0}}, bus.b[31:0]};
      min_val = {{(XLEN-31){1'b1}}, {31{1'b0}}};
    end
  end

  assign a_neg    = sgn & ext_a[XLEN-1];
  assign b_neg    = sgn & ext_b[XLEN-1];
  assign abs_a    = cond_neg(ext_a, a_neg);
  assign abs_b    = cond_neg(ext_b, b_neg);
  assign div_zero = (ext_b == '0);
  assign ovf      = sgn && (ext_a == min_val) && (ext_b == '1);
  assign sp_res   = div_zero ? (bus.op[1] ? ext_a : '1) : (bus.op[1] ? '0 : ext_a);

  // Single XLEN+1 trial subtract; a set top bit of the shifted remainder already
  // guarantees it exceeds the divisor, so only the low XLEN+1 bits are needed.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            keep;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quot_nx;
  logic            last_step;

  assign rem_sh    = {rem, quot[XLEN-1]};
  assign diff      = rem_sh - {1'b0, dvs};
  assign keep      = rem_sh[XLEN] | ~diff[XLEN];
  assign rem_nx    = keep ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quot_nx   = {quot[XLEN-2:0], keep};
  assign last_step = (cnt == (word_q ? CW'(31) : CW'(XLEN-1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.result    <= '0;
      is_rem        <= 1'b0;
      word_q        <= 1'b0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      rem           <= '0;
      quot          <= '0;
      dvs           <= '0;
      cnt           <= '0;
    end else if (bus.flush) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            is_rem       <= bus.op[1];
            word_q       <= bus.word;
            q_neg        <= a_neg ^ b_neg;
            r_neg        <= a_neg;
            rem          <= '0;
            // W dividends sit in the top half so 32 shifts drain them into rem.
            quot         <= bus.word ? {abs_a[31:0], 32'b0} : abs_a;
            dvs          <= abs_b;
            cnt          <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (div_zero || ovf) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.result    <= fix_w(sp_res, bus.word);
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt + 1'b1;
          if (last_step) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= fix_w(is_rem ? cond_neg(rem_nx, r_neg) : cond_neg(quot_nx, q_neg), word_q);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed-vector bench for the divide sequencer.
module tb_mdu_div_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  mdu_div_if #(.XLEN(64)) dif ();

  mdu_div_ctrl #(.XLEN(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic fire_req(input logic [1:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    dif.op       = o;
    dif.word     = w;
    dif.a        = x;
    dif.b        = y;
    dif.in_valid = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    dif.a        = {$urandom, $urandom};
    dif.b        = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!dif.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 64'(dif.out_valid), 64'd0);
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] exp, input int lat);
    int n;
    fire_req(o, w, x, y);
    wait_valid(n);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk(tag, dif.result, exp);
    accept(tag);
  endtask

  initial begin
    int n;
    logic [63:0] held;
    logic seen;
    n_vec = 0;
    n_bad = 0;
    reset         = 1'b1;
    dif.in_valid  = 1'b0;
    dif.op        = 2'b00;
    dif.word      = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    dif.flush     = 1'b0;
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(dif.in_ready), 64'd1);
    chk("rst_out_valid", 64'(dif.out_valid), 64'd0);
    chk("rst_busy", 64'(dif.busy), 64'd0);
    chk("rst_result", dif.result, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("divu_100_7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    do_op("remu_100_7", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    do_op("div_m7_2",   2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem_m7_2",   2'b10, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("rem_7_m2",   2'b10, 1'b0, 64'd7, -64'sd2, 64'd1, 65);
    do_op("divu_by0",   2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem_by0",    2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    do_op("div_ovf",    2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
          64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf",    2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    do_op("divw_ovf",   2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    do_op("divuw_a",    2'b01, 1'b1, 64'h1_FFFF_FFFE, 64'd2, 64'h7FFF_FFFF, 33);
    do_op("remuw",      2'b11, 1'b1, 64'hFFFF_FFFF, 64'h10, 64'hF, 33);
    do_op("divuw_sx",   2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    do_op("divw_m7_2",  2'b00, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    do_op("remw_m7_2",  2'b10, 1'b1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);

    // Result held while out_ready stays low.
    fire_req(2'b01, 1'b0, 64'd100, 64'd7);
    wait_valid(n);
    chk("hold_lat", 64'(n), 64'd65);
    held = dif.result;
    chk("hold_first", held, 64'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_result", dif.result, 64'd14);
      chk("hold_in_ready", 64'(dif.in_ready), 64'd0);
      chk("hold_valid", 64'(dif.out_valid), 64'd1);
    end
    accept("hold");
    chk("hold_idle_ready", 64'(dif.in_ready), 64'd1);

    // Flush at CALC cycle 10: nothing is emitted afterwards.
    fire_req(2'b01, 1'b0, 64'd1000, 64'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    chk("flush_busy", 64'(dif.busy), 64'd0);
    chk("flush_in_ready", 64'(dif.in_ready), 64'd1);
    chk("flush_out_valid", 64'(dif.out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (dif.out_valid) seen = 1'b1;
    end
    chk("flush_no_result", 64'(seen), 64'd0);
    do_op("after_flush", 2'b01, 1'b0, 64'd1000, 64'd3, 64'd333, 65);

    // Flush coinciding with a request drops the request.
    @(negedge clk);
    dif.op = 2'b01; dif.word = 1'b0; dif.a = 64'd9; dif.b = 64'd0;
    dif.in_valid = 1'b1;
    dif.flush    = 1'b1;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    dif.flush    = 1'b0;
    chk("flush_fire_busy", 64'(dif.busy), 64'd0);
    chk("flush_fire_valid", 64'(dif.out_valid), 64'd0);

    // Reset mid-CALC returns every output to its reset value.
    fire_req(2'b00, 1'b0, 64'd77, 64'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 64'(dif.in_ready), 64'd1);
    chk("midrst_out_valid", 64'(dif.out_valid), 64'd0);
    chk("midrst_busy", 64'(dif.busy), 64'd0);
    chk("midrst_result", dif.result, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("after_rst", 2'b00, 1'b0, 64'd77, 64'd5, 64'd15, 65);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
